// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   op_t / OP_ADD / OP_SUB : operation select carried alongside each operand pair
//   stages(n, block)       : pipeline depth, which is also the latency in cycles
package adder_pkg;

  typedef logic op_t;

  localparam op_t OP_ADD = 1'b0;
  localparam op_t OP_SUB = 1'b1;

  // Guarded so a zero BLOCK reaches the top-level elaboration check instead of dividing by zero.
  function automatic int unsigned stages(input int unsigned n, input int unsigned block);
    return (block == 0) ? 0 : n / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational W-bit carry-lookahead slice.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : a + b + cin, low W bits
//   cout  : carry out of bit W-1
//   c_msb : carry into bit W-1 (paired with cout for signed overflow)
module cla_block #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & cin).
  always_comb begin
    logic pp;
    c  = '0;
    pp = 1'b1;
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      for (int j = 0; j <= i; j++) begin
        pp = 1'b1;
        for (int m = j + 1; m <= i; m++) begin
          pp = pp & p[m];
        end
        c[i+1] = c[i+1] | (g[j] & pp);
      end
      pp = 1'b1;
      for (int m = 0; m <= i; m++) begin
        pp = pp & p[m];
      end
      c[i+1] = c[i+1] | (cin & pp);
    end
  end

  assign sum   = p ^ c[W-1:0];
  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit add/subtract: one BLOCK-bit CLA slice per stage, carry registered between stages.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (op, x, y)
//   out_valid / out_ready: result handshake (result, ovf)
//   result               : N-bit sum/difference plus carry (add) or borrow (sub) in bit N
//   ovf                  : signed overflow of the N-bit result
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned BLOCK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_t          op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result,
  output logic         ovf
);

  localparam int unsigned STAGES = stages(N, BLOCK);

  if (BLOCK < 1) begin : g_bad_block
    $error("pipelined_cla_adder: BLOCK must be at least 1");
  end else if (N % BLOCK != 0) begin : g_bad_width
    $error("pipelined_cla_adder: N must be a multiple of BLOCK");
  end

  // Subtract is x + ~y + 1; the inversion happens once, before the operand enters the pipe.
  logic [N-1:0]    y_eff;
  logic [STAGES-1:0] vld_vec;
  logic [STAGES:0]   rdy;

  assign y_eff = (op == OP_SUB) ? ~y : y;

  // Backward ready chain: a stage can load when it is empty or its successor can load.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rdy[i] = !vld_vec[i] || rdy[i+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be summed after this stage.
    localparam int unsigned REM = N - (k + 1) * BLOCK;

    logic                   src_vld;
    op_t                    src_op;
    logic                   src_cy;
    logic [BLOCK-1:0]       src_a;
    logic [BLOCK-1:0]       src_b;
    logic [(k+1)*BLOCK-1:0] sum_d;
    logic [BLOCK-1:0]       slice_sum;
    logic                   slice_cout;
    logic                   slice_cmsb;
    logic                   load;
    logic                   vld_q;
    logic [(k+1)*BLOCK-1:0] sum_q;

    if (k == 0) begin : g_src
      assign src_vld = in_valid;
      assign src_op  = op;
      assign src_cy  = (op == OP_SUB);
      assign src_a   = x[BLOCK-1:0];
      assign src_b   = y_eff[BLOCK-1:0];
      assign sum_d   = slice_sum;
    end else begin : g_src
      assign src_vld = g_stage[k-1].vld_q;
      assign src_op  = g_stage[k-1].g_carry.op_q;
      assign src_cy  = g_stage[k-1].g_carry.cy_q;
      assign src_a   = g_stage[k-1].g_opnd.a_q[BLOCK-1:0];
      assign src_b   = g_stage[k-1].g_opnd.b_q[BLOCK-1:0];
      assign sum_d   = {slice_sum, g_stage[k-1].sum_q};
    end

    cla_block #(.W(BLOCK)) u_cla (
      .a     (src_a),
      .b     (src_b),
      .cin   (src_cy),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
    );

    assign load       = rdy[k] && src_vld;
    assign vld_vec[k] = vld_q;

    // Valid moves whenever the stage advances; payload only loads with a real op.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else begin
        if (rdy[k]) vld_q <= src_vld;
        if (load)   sum_q <= sum_d;
      end
    end

    // Upper operand bits not yet consumed, shifted down so the next slice is always at bit 0.
    if (REM > 0) begin : g_opnd
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_from
        assign a_d = x[N-1:BLOCK];
        assign b_d = y_eff[N-1:BLOCK];
      end else begin : g_from
        assign a_d = g_stage[k-1].g_opnd.a_q[REM+BLOCK-1:BLOCK];
        assign b_d = g_stage[k-1].g_opnd.b_q[REM+BLOCK-1:BLOCK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_carry
      op_t  op_q;
      logic cy_q;
      // Carry into a slice MSB only matters at the word MSB.
      logic cmsb_unused;
      assign cmsb_unused = slice_cmsb;

      always_ff @(posedge clk) begin
        if (rst) begin
          op_q <= OP_ADD;
          cy_q <= 1'b0;
        end else if (load) begin
          op_q <= src_op;
          cy_q <= slice_cout;
        end
      end
    end else begin : g_last
      logic hi_q;
      logic ovf_q;

      // Bit N is the carry for add and the borrow (inverted carry) for subtract.
      always_ff @(posedge clk) begin
        if (rst) begin
          hi_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (load) begin
          hi_q  <= (src_op == OP_SUB) ? ~slice_cout : slice_cout;
          ovf_q <= slice_cout ^ slice_cmsb;
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = g_stage[STAGES-1].vld_q;
  assign result    = {g_stage[STAGES-1].g_last.hi_q, g_stage[STAGES-1].sum_q};
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
